// File: rtl/vx_writeback_arb_pkg.sv
// rtl/vx_writeback_arb_pkg.sv - shared GPU writeback types: requester ids and payload packing
package vx_writeback_arb_pkg;

   localparam int NUM_THREADS = 4;
   localparam int NW_BITS     = 2;
   localparam int NR_BITS     = 5;

   localparam int REQ_ALU     = 0;
   localparam int REQ_LD      = 1;
   localparam int REQ_CSR     = 2;
   localparam int REQ_FPU     = 3;
   localparam int REQ_GPU     = 4;
   localparam int NUM_WB_REQS = 5;

   typedef struct packed {
      logic [NW_BITS-1:0]       wid;
      logic [31:0]              pc;
      logic [NUM_THREADS-1:0]   tmask;
      logic [NR_BITS-1:0]       rd;
      logic [32*NUM_THREADS-1:0] data;
   } wb_payload_t;

   localparam int WB_DATAW = $bits(wb_payload_t);

endpackage

// File: rtl/vx_writeback_arb_elastic_buffer.sv
// rtl/vx_writeback_arb_elastic_buffer.sv - 2-entry elastic buffer, head always in slot 0
module vx_writeback_arb_elastic_buffer #(
   parameter int DATAW = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [DATAW-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [DATAW-1:0] out_data,
   input  logic             out_ready
);

   logic             valid0_q, valid0_d;
   logic             valid1_q, valid1_d;
   logic [DATAW-1:0] data0_q, data0_d;
   logic [DATAW-1:0] data1_q, data1_d;

   // A full buffer still accepts when the head drains in the same cycle.
   assign in_ready  = !valid1_q || out_ready;
   assign out_valid = valid0_q;
   assign out_data  = data0_q;

   always_comb begin
      valid0_d = valid0_q;
      valid1_d = valid1_q;
      data0_d  = data0_q;
      data1_d  = data1_q;
      if (valid0_q && out_ready) begin
         if (valid1_q) begin
            data0_d  = data1_q;
            valid1_d = 1'b0;
         end else begin
            valid0_d = 1'b0;
         end
      end
      if (in_valid && in_ready) begin
         if (!valid0_d) begin
            data0_d  = in_data;
            valid0_d = 1'b1;
         end else begin
            data1_d  = in_data;
            valid1_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
      end else begin
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
      end
   end

   always_ff @(posedge clk) begin
      data0_q <= data0_d;
      data1_q <= data1_d;
   end

endmodule

// File: rtl/vx_writeback_arb.sv
// rtl/vx_writeback_arb.sv - round-robin commit writeback arbiter feeding a 2-entry elastic buffer
// Optional packet lock on multi-beat writebacks: define WB_ARB_LOCK_EN.
module vx_writeback_arb
   import vx_writeback_arb_pkg::*;
#(
   parameter int NUM_REQS = NUM_WB_REQS,
   parameter int DATAW    = WB_DATAW
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid,
   input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
   input  logic [NUM_REQS-1:0]            req_eop,
   output logic [NUM_REQS-1:0]            req_ready,
   output logic                           wb_valid,
   output logic [DATAW-1:0]               wb_data,
   output logic                           wb_eop,
   input  logic                           wb_ready
);

   localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             grant_valid;
   logic [PTR_W-1:0] grant_idx;
   logic             buf_in_valid;
   logic             buf_in_ready;
   logic             xfer;
   logic             xfer_eop;
   logic [DATAW:0]   buf_out_data;

`ifdef WB_ARB_LOCK_EN
   logic             lock_q, lock_d;
   logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
`endif

   always_comb begin : rr_select
      int               idx;
      logic [PTR_W-1:0] idx_w;
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      idx_w       = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQS) idx = idx - NUM_REQS;
         idx_w = PTR_W'(idx);
         if (!grant_valid && req_valid[idx_w]) begin
            grant_valid = 1'b1;
            grant_idx   = idx_w;
         end
      end
`ifdef WB_ARB_LOCK_EN
      // While a packet is open only its owner may be granted, even if it idles.
      if (lock_q) begin
         grant_valid = req_valid[lock_idx_q];
         grant_idx   = lock_idx_q;
      end
`endif
   end

   assign buf_in_valid = grant_valid && !reset;
   assign xfer         = buf_in_valid && buf_in_ready;
   assign xfer_eop     = req_eop[grant_idx];

   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer && xfer_eop)
         rr_ptr_d = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

`ifdef WB_ARB_LOCK_EN
   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         lock_d     = !xfer_eop;
         lock_idx_d = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end
`endif

   vx_writeback_arb_elastic_buffer #(
      .DATAW (DATAW + 1)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (buf_in_valid),
      .in_data   ({xfer_eop, req_data[grant_idx]}),
      .in_ready  (buf_in_ready),
      .out_valid (wb_valid),
      .out_data  (buf_out_data),
      .out_ready (wb_ready)
   );

   assign wb_eop  = buf_out_data[DATAW];
   assign wb_data = buf_out_data[DATAW-1:0];

endmodule
